// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM stage: access sizes, FSM states, byte-enable patterns.
package mem_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // The reserved encoding 2'b11 behaves as a word access.
  function automatic mem_size_t decode_size(input logic [1:0] raw);
    return (raw == 2'b11) ? WORD : mem_size_t'(raw);
  endfunction

endpackage

// File: rtl/mem_if.sv
// Request/acknowledge data bus between the MEM stage (master) and memory (slave).
interface mem_if #(
  parameter int ADDR_W = 32
);
  logic              BusReq;
  logic              BusWe;
  logic [ADDR_W-1:0] BusAddr;
  logic [31:0]       BusWData;
  logic [3:0]        BusBe;
  logic              BusAck;
  logic [31:0]       BusRData;

  modport master (
    output BusReq, BusWe, BusAddr, BusWData, BusBe,
    input  BusAck, BusRData
  );

  modport slave (
    input  BusReq, BusWe, BusAddr, BusWData, BusBe,
    output BusAck, BusRData
  );
endinterface

// File: rtl/mem_lane.sv
// Combinational lane logic: store replication, byte-enable generation, little-endian load extend.
module mem_lane
  import mem_pkg::*;
(
  input  mem_size_t   size,
  input  logic [1:0]  lane,
  input  logic        sgn,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] bus_wdata,
  output logic [3:0]  be,
  output logic [31:0] load_data
);
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    bus_wdata = wdata;
    be        = BE_WORD;
    load_data = rdata;
    rd_byte   = rdata[{lane, 3'b000} +: 8];
    rd_half   = rdata[{lane[1], 4'b0000} +: 16];
    case (size)
      BYTE: begin
        bus_wdata = {4{wdata[7:0]}};
        be        = BE_BYTE << lane;
        load_data = {{24{sgn & rd_byte[7]}}, rd_byte};
      end
      HALF: begin
        // Only addr[1] picks the half; addr[0] is ignored here.
        bus_wdata = {2{wdata[15:0]}};
        be        = BE_HALF << {lane[1], 1'b0};
        load_data = {{16{sgn & rd_half[15]}}, rd_half};
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: IDLE/WAIT bus FSM with timeout, stall generation and MEM/WB register.
// Define MEM_ALIGN_CHECK_EN to trap misaligned half/word accesses (AlignErrW) instead of issuing them.
module mem_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic        RegWriteM,
  input  logic        MemToRegM,
  input  logic [1:0]  MemSizeM,
  input  logic        MemSignedM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  WriteRegM,
  mem_if.master       bus,
  output logic        StallM,
  output logic        RegWriteW,
  output logic        MemToRegW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUOutW,
  output logic [4:0]  WriteRegW,
  output logic        BusErrW,
  output logic        AlignErrW
);
  localparam int CNT_W = $clog2(TIMEOUT);

  mem_state_t       state;
  logic [CNT_W-1:0] cnt;
  mem_size_t        size;
  logic             mem_op, misalign, req_ok, req, timeout_hit;
  logic [31:0]      store_wdata, load_data;
  logic [3:0]       store_be;

  assign size   = decode_size(MemSizeM);
  assign mem_op = MemReadM | MemWriteM;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = mem_op & (((size == HALF) & ALUOutM[0]) |
                              ((size == WORD) & (ALUOutM[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign req_ok = mem_op & ~misalign;

  always_comb begin
    req         = 1'b0;
    StallM      = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        req    = req_ok;
        StallM = req_ok & ~bus.BusAck;
      end
      WAIT: begin
        req         = 1'b1;
        timeout_hit = ~bus.BusAck & (cnt == CNT_W'(TIMEOUT - 1));
        StallM      = ~bus.BusAck & ~timeout_hit;
      end
      default: ;
    endcase
  end

  mem_lane u_lane (
    .size      (size),
    .lane      (ALUOutM[1:0]),
    .sgn       (MemSignedM),
    .wdata     (WriteDataM),
    .rdata     (bus.BusRData),
    .bus_wdata (store_wdata),
    .be        (store_be),
    .load_data (load_data)
  );

  // Upstream is frozen by StallM, so bus outputs can come straight from the M inputs.
  assign bus.BusReq   = req & ~reset;
  assign bus.BusWe    = MemWriteM;
  assign bus.BusAddr  = ADDR_W'({ALUOutM[31:2], 2'b00});
  assign bus.BusWData = store_wdata;
  assign bus.BusBe    = store_be;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      RegWriteW <= 1'b0;
      MemToRegW <= 1'b0;
      ReadDataW <= '0;
      ALUOutW   <= '0;
      WriteRegW <= '0;
      BusErrW   <= 1'b0;
      AlignErrW <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_ok && !bus.BusAck) begin
            state <= WAIT;
            cnt   <= '0;
          end
        end
        WAIT: begin
          if (bus.BusAck || timeout_hit) state <= IDLE;
          else                           cnt   <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase

      if (StallM) begin
        RegWriteW <= 1'b0;
        MemToRegW <= 1'b0;
        BusErrW   <= 1'b0;
        AlignErrW <= 1'b0;
      end else begin
        RegWriteW <= RegWriteM & ~timeout_hit & ~misalign;
        MemToRegW <= MemToRegM;
        ReadDataW <= load_data;
        ALUOutW   <= ALUOutM;
        WriteRegW <= WriteRegM;
        BusErrW   <= timeout_hit;
        AlignErrW <= misalign;
      end
    end
  end
endmodule
